// File: rtl/uart_serial_rx.sv
`default_nettype none
// ============================================================================
// Module   : uart_serial_rx
// Brief    : 16x-NCO UART receiver (8 data bits, optional parity) with FWFT FIFO
// Revision : 1.0
// ============================================================================
module uart_serial_rx #(
   parameter int NcoWidth  = 16,
   parameter int FifoDepth = 4
) (
   input  logic                clk_i,
   input  logic                rst_ni,
   input  logic                rx_en_i,
   input  logic [NcoWidth-1:0] nco_i,
   input  logic                parity_en_i,
   input  logic                parity_odd_i,
   input  logic                rx_i,
   output logic [7:0]          rdata_o,
   output logic                rvalid_o,
   input  logic                rready_i,
   output logic                busy_o,
   output logic                frame_err_o,
   output logic                parity_err_o,
   output logic                overflow_o
);

   localparam int PtrW = (FifoDepth > 1) ? $clog2(FifoDepth) : 1;

   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      START  = 3'd1,
      DATA   = 3'd2,
      PARITY = 3'd3,
      STOP   = 3'd4
   } state_e;

   logic                rx_meta_q, rx_s_q;
   logic [NcoWidth-1:0] acc_q;
   logic                tick_q;
   logic [NcoWidth:0]   w_sum;

   state_e     state_q, state_d;
   logic [3:0] tick_cnt_q, tick_cnt_d;
   logic [2:0] bit_cnt_q, bit_cnt_d;
   logic [7:0] shift_q, shift_d;
   logic       par_en_q, par_en_d;
   logic       par_odd_q, par_odd_d;
   logic       par_err_q, par_err_d;
   logic       push_q, push_d;
   logic       ferr_q, ferr_d;
   logic       perr_q, perr_d;

   logic [7:0]      mem_q [FifoDepth];
   logic [PtrW-1:0] wr_ptr_q, rd_ptr_q;
   logic [PtrW:0]   count_q;
   logic            ovf_q;
   logic            w_full, w_pop, w_push;

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         rx_meta_q <= 1'b1;
         rx_s_q    <= 1'b1;
      end else begin
         rx_meta_q <= rx_i;
         rx_s_q    <= rx_meta_q;
      end
   end

   // The tick is the registered carry out of the phase accumulator.
   assign w_sum = {1'b0, acc_q} + {1'b0, nco_i};

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         acc_q  <= '0;
         tick_q <= 1'b0;
      end else if (!rx_en_i) begin
         acc_q  <= '0;
         tick_q <= 1'b0;
      end else begin
         acc_q  <= w_sum[NcoWidth-1:0];
         tick_q <= w_sum[NcoWidth];
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q    <= IDLE;
         tick_cnt_q <= '0;
         bit_cnt_q  <= '0;
         shift_q    <= '0;
         par_en_q   <= 1'b0;
         par_odd_q  <= 1'b0;
         par_err_q  <= 1'b0;
         push_q     <= 1'b0;
         ferr_q     <= 1'b0;
         perr_q     <= 1'b0;
      end else begin
         state_q    <= state_d;
         tick_cnt_q <= tick_cnt_d;
         bit_cnt_q  <= bit_cnt_d;
         shift_q    <= shift_d;
         par_en_q   <= par_en_d;
         par_odd_q  <= par_odd_d;
         par_err_q  <= par_err_d;
         push_q     <= push_d;
         ferr_q     <= ferr_d;
         perr_q     <= perr_d;
      end
   end

   always_comb begin
      state_d    = state_q;
      tick_cnt_d = tick_cnt_q;
      bit_cnt_d  = bit_cnt_q;
      shift_d    = shift_q;
      par_en_d   = par_en_q;
      par_odd_d  = par_odd_q;
      par_err_d  = par_err_q;
      push_d     = 1'b0;
      ferr_d     = 1'b0;
      perr_d     = 1'b0;
      if (!rx_en_i) begin
         state_d = IDLE;
      end else if (tick_q) begin
         case (state_q)
            IDLE: begin
               if (!rx_s_q) begin
                  state_d    = START;
                  tick_cnt_d = '0;
               end
            end
            START: begin
               tick_cnt_d = tick_cnt_q + 4'd1;
               if (tick_cnt_q == 4'd7) begin
                  if (!rx_s_q) begin
                     state_d    = DATA;
                     tick_cnt_d = '0;
                     bit_cnt_d  = '0;
                     par_en_d   = parity_en_i;
                     par_odd_d  = parity_odd_i;
                     par_err_d  = 1'b0;
                  end else begin
                     state_d = IDLE;
                  end
               end
            end
            DATA: begin
               tick_cnt_d = tick_cnt_q + 4'd1;
               if (tick_cnt_q == 4'd15) begin
                  shift_d   = {rx_s_q, shift_q[7:1]};
                  bit_cnt_d = bit_cnt_q + 3'd1;
                  if (bit_cnt_q == 3'd7) begin
                     state_d = par_en_q ? PARITY : STOP;
                  end
               end
            end
            PARITY: begin
               tick_cnt_d = tick_cnt_q + 4'd1;
               if (tick_cnt_q == 4'd15) begin
                  par_err_d = ((^shift_q) ^ rx_s_q) != par_odd_q;
                  state_d   = STOP;
               end
            end
            STOP: begin
               tick_cnt_d = tick_cnt_q + 4'd1;
               // Leave at mid-stop-bit so a back-to-back start edge is not missed.
               if (tick_cnt_q == 4'd15) begin
                  state_d = IDLE;
                  ferr_d  = !rx_s_q;
                  perr_d  = par_err_q;
                  push_d  = rx_s_q & !par_err_q;
               end
            end
            default: state_d = IDLE;
         endcase
      end
   end

   assign w_full = (count_q == (PtrW + 1)'(FifoDepth));
   assign w_pop  = (count_q != '0) & rready_i;
   assign w_push = push_q & (!w_full | w_pop);

   always_ff @(posedge clk_i) begin
      if (w_push) begin
         mem_q[wr_ptr_q] <= shift_q;
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
         ovf_q    <= 1'b0;
      end else begin
         ovf_q <= push_q & w_full & !w_pop;
         if (w_push) begin
            wr_ptr_q <= wr_ptr_q + 1'b1;
         end
         if (w_pop) begin
            rd_ptr_q <= rd_ptr_q + 1'b1;
         end
         if (w_push && !w_pop) begin
            count_q <= count_q + 1'b1;
         end else if (!w_push && w_pop) begin
            count_q <= count_q - 1'b1;
         end
      end
   end

   assign rvalid_o     = (count_q != '0);
   assign rdata_o      = rvalid_o ? mem_q[rd_ptr_q] : 8'h00;
   assign busy_o       = (state_q != IDLE);
   assign frame_err_o  = ferr_q;
   assign parity_err_o = perr_q;
   assign overflow_o   = ovf_q;

endmodule
`default_nettype wire

// File: tb/tb_uart_serial_rx.sv
`default_nettype none
// ============================================================================
// Module   : tb_uart_serial_rx
// Brief    : Directed, table-driven self-checking bench for uart_serial_rx
// Revision : 1.0
// ============================================================================
module tb_uart_serial_rx;

   logic        clk = 1'b0;
   logic        rst_ni = 1'b0;
   logic        rx_en_i = 1'b0;
   logic [15:0] nco_i = 16'h8000;
   logic        parity_en_i = 1'b0;
   logic        parity_odd_i = 1'b0;
   logic        rx_i = 1'b1;
   logic        rready_i = 1'b0;
   logic [7:0]  rdata_o;
   logic        rvalid_o, busy_o, frame_err_o, parity_err_o, overflow_o;

   uart_serial_rx #(.NcoWidth(16), .FifoDepth(4)) dut (
      .clk_i        (clk),
      .rst_ni       (rst_ni),
      .rx_en_i      (rx_en_i),
      .nco_i        (nco_i),
      .parity_en_i  (parity_en_i),
      .parity_odd_i (parity_odd_i),
      .rx_i         (rx_i),
      .rdata_o      (rdata_o),
      .rvalid_o     (rvalid_o),
      .rready_i     (rready_i),
      .busy_o       (busy_o),
      .frame_err_o  (frame_err_o),
      .parity_err_o (parity_err_o),
      .overflow_o   (overflow_o)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;
   int n_ferr = 0;
   int n_perr = 0;
   int n_ovf  = 0;

   // Counting high cycles also catches a flag that sticks for more than one cycle.
   always @(negedge clk) begin
      if (frame_err_o)  n_ferr <= n_ferr + 1;
      if (parity_err_o) n_perr <= n_perr + 1;
      if (overflow_o)   n_ovf  <= n_ovf + 1;
   end

   typedef struct {
      logic [7:0] data;
      logic       pen;
      logic       podd;
      logic       pbit;
      logic       stop;
      logic       exp_push;
      int         exp_ferr;
      int         exp_perr;
   } vec_t;

   vec_t vecs[9];

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   task automatic idle(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic send(input logic [7:0] d, input logic pen, input logic pbit, input logic stop);
      rx_i = 1'b0;
      idle(32);
      for (int i = 0; i < 8; i++) begin
         rx_i = d[i];
         idle(32);
      end
      if (pen) begin
         rx_i = pbit;
         idle(32);
      end
      rx_i = stop;
      idle(32);
      rx_i = 1'b1;
   endtask

   task automatic pop(input string nm, input logic [7:0] exp);
      chk({nm, " rvalid"}, {31'd0, rvalid_o}, 32'd1);
      chk({nm, " rdata"}, {24'd0, rdata_o}, {24'd0, exp});
      rready_i = 1'b1;
      @(negedge clk);
      rready_i = 1'b0;
   endtask

   initial begin
      #600000;
      $display("FAIL timeout: simulation did not finish, got running expected done");
      $fatal(1, "timeout");
   end

   initial begin
      int f0, p0, o0;

      vecs[0] = '{8'hAF, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 0, 0};
      vecs[1] = '{8'h55, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1, 0};
      vecs[2] = '{8'h3C, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 0, 0};
      vecs[3] = '{8'h03, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 0, 1};
      vecs[4] = '{8'h03, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 0, 0};
      vecs[5] = '{8'h03, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 0, 0};
      vecs[6] = '{8'h03, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 0, 1};
      vecs[7] = '{8'h03, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1, 1};
      vecs[8] = '{8'h80, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 0, 0};

      idle(3);
      chk("reset rdata", {24'd0, rdata_o}, 32'd0);
      chk("reset rvalid", {31'd0, rvalid_o}, 32'd0);
      chk("reset busy", {31'd0, busy_o}, 32'd0);
      chk("reset frame_err", {31'd0, frame_err_o}, 32'd0);
      chk("reset parity_err", {31'd0, parity_err_o}, 32'd0);
      chk("reset overflow", {31'd0, overflow_o}, 32'd0);

      rst_ni  = 1'b1;
      rx_en_i = 1'b1;
      idle(10);

      for (int v = 0; v < 9; v++) begin
         parity_en_i  = vecs[v].pen;
         parity_odd_i = vecs[v].podd;
         f0 = n_ferr; p0 = n_perr; o0 = n_ovf;
         send(vecs[v].data, vecs[v].pen, vecs[v].pbit, vecs[v].stop);
         idle(48);
         chk($sformatf("vec%0d frame_err", v), n_ferr - f0, vecs[v].exp_ferr);
         chk($sformatf("vec%0d parity_err", v), n_perr - p0, vecs[v].exp_perr);
         chk($sformatf("vec%0d overflow", v), n_ovf - o0, 0);
         chk($sformatf("vec%0d busy", v), {31'd0, busy_o}, 32'd0);
         chk($sformatf("vec%0d rvalid", v), {31'd0, rvalid_o}, {31'd0, vecs[v].exp_push});
         if (vecs[v].exp_push) begin
            pop($sformatf("vec%0d pop", v), vecs[v].data);
            chk($sformatf("vec%0d empty", v), {31'd0, rvalid_o}, 32'd0);
         end
      end
      parity_en_i  = 1'b0;
      parity_odd_i = 1'b0;

      // Back-to-back frames with no idle gap.
      f0 = n_ferr;
      send(8'hAF, 1'b0, 1'b0, 1'b1);
      send(8'hAA, 1'b0, 1'b0, 1'b1);
      idle(48);
      chk("b2b frame_err", n_ferr - f0, 0);
      pop("b2b first", 8'hAF);
      pop("b2b second", 8'hAA);
      chk("b2b empty", {31'd0, rvalid_o}, 32'd0);

      // Start-bit glitch: 6 clk low is shorter than the mid-start check.
      f0 = n_ferr; p0 = n_perr;
      rx_i = 1'b0;
      idle(6);
      rx_i = 1'b1;
      chk("glitch busy during", {31'd0, busy_o}, 32'd1);
      idle(48);
      chk("glitch busy after", {31'd0, busy_o}, 32'd0);
      chk("glitch rvalid", {31'd0, rvalid_o}, 32'd0);
      chk("glitch errors", (n_ferr - f0) + (n_perr - p0), 0);

      // Overflow: five frames into a four-entry FIFO.
      o0 = n_ovf;
      for (int b = 1; b <= 5; b++) begin
         send(8'(b), 1'b0, 1'b0, 1'b1);
         idle(16);
      end
      idle(32);
      chk("overflow pulses", n_ovf - o0, 1);
      for (int b = 1; b <= 4; b++) begin
         pop($sformatf("overflow read%0d", b), 8'(b));
      end
      chk("overflow drained", {31'd0, rvalid_o}, 32'd0);

      // Receiver disable mid-frame drops the partial byte silently.
      f0 = n_ferr;
      rx_i = 1'b0; idle(32);
      rx_i = 1'b1; idle(32);
      chk("disable busy before", {31'd0, busy_o}, 32'd1);
      rx_en_i = 1'b0;
      idle(2);
      chk("disable busy after", {31'd0, busy_o}, 32'd0);
      rx_en_i = 1'b1;
      idle(48);
      chk("disable rvalid", {31'd0, rvalid_o}, 32'd0);
      chk("disable frame_err", n_ferr - f0, 0);

      // Asynchronous reset during DATA, with a byte already queued.
      send(8'h11, 1'b0, 1'b0, 1'b1);
      idle(48);
      chk("prereset rvalid", {31'd0, rvalid_o}, 32'd1);
      rx_i = 1'b0; idle(32);
      rx_i = 1'b1; idle(32);
      rx_i = 1'b0; idle(32);
      chk("prereset busy", {31'd0, busy_o}, 32'd1);
      #2 rst_ni = 1'b0;
      #1;
      chk("async reset busy", {31'd0, busy_o}, 32'd0);
      chk("async reset rvalid", {31'd0, rvalid_o}, 32'd0);
      chk("async reset rdata", {24'd0, rdata_o}, 32'd0);
      rx_i = 1'b1;
      idle(3);
      rst_ni = 1'b1;
      idle(20);
      send(8'hA5, 1'b0, 1'b0, 1'b1);
      idle(48);
      pop("post-reset A5", 8'hA5);
      chk("post-reset empty", {31'd0, rvalid_o}, 32'd0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/uart_serial_rx.md
Name: uart_serial_rx

Overview:
- Standalone UART serial receiver that decodes the 8-bit serial stream driven by the uart peripheral's cio_tx_o.
- Used as the far-end sink for tx loopback checks and as a lightweight rx front-end for SoC debug paths.
- Baud timing uses the same 16x NCO scheme as the uart CTRL.NCO field, so the same NCO value configures both ends.
- Decoded bytes go to a small first-word-fall-through FIFO with a valid/ready read port.

Parameters:
NcoWidth, 16, width of the NCO increment and accumulator
FifoDepth, 4, receive FIFO entries; must be a power of 2, minimum 2

Ports:
clk_i  input  1  clock
rst_ni  input  1  asynchronous active-low reset
rx_en_i  input  1  receiver enable
nco_i  input  NcoWidth  baud increment; 16x tick = carry out of accumulator
parity_en_i  input  1  expect one parity bit after the data bits
parity_odd_i  input  1  1 = odd parity, 0 = even parity
rx_i  input  1  serial line (asynchronous), idle high
rdata_o  output  8  FIFO head byte
rvalid_o  output  1  FIFO not empty
rready_i  input  1  pop FIFO head when rvalid_o is high
busy_o  output  1  FSM not in IDLE
frame_err_o  output  1  single-cycle pulse: stop bit sampled 0
parity_err_o  output  1  single-cycle pulse: parity mismatch
overflow_o  output  1  single-cycle pulse: byte dropped because the FIFO was full

Behaviour:
- Reset values:
  - All outputs 0; rdata_o is 0.
  - Synchronizer flops reset to 1.
  - NCO accumulator, bit counters and FIFO pointers reset to 0.
  - FSM resets to IDLE.
- Synchronizer: rx_i passes through 2 flops; all FSM decisions use the synchronized value rx_s.
- Tick generation:
  - Each clock, {carry, acc} <= acc + nco_i.
  - tick = registered carry.
  - The accumulator holds at 0 while rx_en_i = 0.
  - nco_i = 0 produces no ticks.
- tick_cnt (4 bits) counts ticks within a bit; one bit period = 16 ticks.
- FSM states: IDLE, START, DATA, PARITY, STOP. All state advances happen only on tick cycles.
  - IDLE: when tick and rx_s = 0, go to START and set tick_cnt = 0.
  - START: after 8 ticks (mid-bit), if rx_s = 0 go to DATA and reset tick_cnt; if rx_s = 1 it was a glitch, return to IDLE with no error.
  - DATA: every 16 ticks, shift rx_s in LSB-first. After bit 7, go to PARITY if parity_en_i, else to STOP.
  - PARITY: sample at 16 ticks. Mismatch when (^data ^ sample) != parity_odd_i.
  - STOP: sample at 16 ticks, then return to IDLE in the same step (mid-stop-bit), ready for back-to-back frames.
- Frame outcome:
  - Stop = 1 and parity ok: push the byte.
  - Stop = 0: pulse frame_err_o for 1 cycle and discard the byte.
  - Parity mismatch (with stop = 1): pulse parity_err_o and discard the byte.
  - A frame with both errors pulses both flags in the same cycle.
- parity_en_i and parity_odd_i are sampled when leaving START; they are held for the rest of the frame.
- Push timing: the byte is written on the clock edge after the stop-bit sample. rvalid_o rises 1 cycle later (registered FIFO count).
- FIFO:
  - Pop occurs when rvalid_o & rready_i.
  - Push when full: byte dropped, overflow_o pulses 1 cycle, FIFO contents unchanged.
  - Push and pop in the same cycle when full: both happen, no overflow.
  - Push and pop in the same cycle when empty: no-op for pop, push accepted.
  - Pointers wrap modulo FifoDepth; occupancy counter is log2(FifoDepth)+1 bits.
- rx_en_i = 0:
  - FSM returns to IDLE on the next cycle and any partial frame is discarded without error.
  - FIFO contents and the read port remain usable.
- busy_o = (state != IDLE).
- Asynchronous reset mid-frame: everything returns to reset values immediately. The next start bit is detected normally after rst_ni deasserts and rx_s returns high then low.

Test Plan:
- Nominal 8N1: rx_en=1, nco=16'h8000 (tick every 2 clk, bit = 32 clk), send 0xAF → rvalid_o high, rdata_o=0xAF, no error pulses; pop with rready → rvalid_o=0.
- Back-to-back frames: send 0xAF then 0xAA with no idle gap → FIFO holds 0xAF, 0xAA in order; no frame_err.
- Start-bit glitch: rx_i low for 6 clk (3 ticks) then high → no push, busy_o returns 0, no error pulses.
- Framing error: send 0x55 with stop bit 0 → frame_err_o pulses once, rvalid_o stays 0; next good frame 0x3C is received correctly.
- Parity: parity_en=1, even; send 0x03 with parity bit 1 → parity_err_o pulse, no push. Send 0x03 with parity bit 0 → 0x03 received. Set parity_odd=1; send 0x03 with parity 1 → received.
- Overflow and reset: send 0x01..0x05 with rready=0 → 4 entries, overflow_o pulses on 5th; reads return 0x01..0x04. Then assert rst_ni low during the DATA state of a frame → rvalid_o=0, busy_o=0 immediately; a subsequent 0xA5 frame is received correctly.
